// File: rtl/accelerator_sort_pkg.sv
// Shared types and constants for the DNC usage-sort controller and its buffer.
// Holds the FSM state encoding and the sizing helper used by both modules.
package accelerator_sort_pkg;

   localparam int DATA_SIZE_DEF    = 64;
   localparam int CONTROL_SIZE_DEF = 64;
   localparam int DEPTH_DEF        = 8;
   localparam int ADDR_SIZE        = $clog2(DEPTH_DEF);

   localparam logic [DATA_SIZE_DEF-1:0]    ZERO_DATA    = '0;
   localparam logic [DATA_SIZE_DEF-1:0]    ONE_DATA     = {{(DATA_SIZE_DEF-1){1'b0}}, 1'b1};
   localparam logic [CONTROL_SIZE_DEF-1:0] ZERO_CONTROL = '0;
   localparam logic [CONTROL_SIZE_DEF-1:0] ONE_CONTROL  = {{(CONTROL_SIZE_DEF-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SCAN,
      ST_EMIT,
      ST_DONE
   } state_t;

   // Address width for a buffer of the given depth; never narrower than one bit.
   function automatic int addr_size_f(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/accelerator_sort_buffer.sv
// Usage-vector storage: DEPTH registers with one write port and an async read port,
// plus the per-entry "already emitted" flags with set and clear-all controls.
module accelerator_sort_buffer
   import accelerator_sort_pkg::*;
#(
   parameter int DATA_SIZE = 64,
   parameter int DEPTH     = 8,
   parameter int AW        = addr_size_f(DEPTH)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 wr_en_i,
   input  logic [AW-1:0]        wr_addr_i,
   input  logic [DATA_SIZE-1:0] wr_data_i,
   input  logic [AW-1:0]        rd_addr_i,
   output logic [DATA_SIZE-1:0] rd_data_o,
   input  logic                 used_set_i,
   input  logic [AW-1:0]        used_set_addr_i,
   input  logic                 used_clear_i,
   output logic [DEPTH-1:0]     used_o
);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]     used_q;

   // Data storage carries no reset; contents are only read after being loaded.
   always_ff @(posedge CLK) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         used_q <= '0;
      end else if (used_clear_i) begin
         used_q <= '0;
      end else if (used_set_i) begin
         used_q[used_set_addr_i] <= 1'b1;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];
   assign used_o    = used_q;

endmodule

// File: rtl/accelerator_sort_controller.sv
// Load/scan/emit sequencer producing the DNC free list: indices of the usage vector
// in ascending usage order (lowest index wins ties), one index per n+1 cycles.
module accelerator_sort_controller
   import accelerator_sort_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64,
   parameter int DEPTH        = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic                 U_IN_ENABLE,
   output logic                 U_OUT_ENABLE,
   output logic                 PHI_OUT_ENABLE,
   input  logic [DATA_SIZE-1:0] SIZE_N_IN,
   input  logic [DATA_SIZE-1:0] U_IN,
   output logic [DATA_SIZE-1:0] PHI_OUT
);

   localparam int AW = addr_size_f(DEPTH);
   localparam int CW = (CONTROL_SIZE > AW) ? AW + 1 : CONTROL_SIZE;
   localparam logic [CW-1:0] ONE_CW = CW'(1);

   state_t               state_q, state_d;
   logic [CW-1:0]        n_q, n_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [CW-1:0]        j_q, j_d;
   logic [CW-1:0]        emit_q, emit_d;
   logic                 best_valid_q, best_valid_d;
   logic [AW-1:0]        best_idx_q, best_idx_d;
   logic [DATA_SIZE-1:0] best_val_q, best_val_d;
   logic [AW-1:0]        phi_q, phi_d;

   logic [CW-1:0]        n_start;
   logic                 take;
   logic                 wr_en;
   logic                 used_set;
   logic                 used_clr;
   logic [DATA_SIZE-1:0] rd_data;
   logic [DEPTH-1:0]     used;

   accelerator_sort_buffer #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH),
      .AW        (AW)
   ) u_buffer (
      .CLK             (CLK),
      .RST             (RST),
      .wr_en_i         (wr_en),
      .wr_addr_i       (cnt_q[AW-1:0]),
      .wr_data_i       (U_IN),
      .rd_addr_i       (j_q[AW-1:0]),
      .rd_data_o       (rd_data),
      .used_set_i      (used_set),
      .used_set_addr_i (phi_q),
      .used_clear_i    (used_clr),
      .used_o          (used)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         n_q          <= '0;
         cnt_q        <= '0;
         j_q          <= '0;
         emit_q       <= '0;
         best_valid_q <= 1'b0;
         best_idx_q   <= '0;
         phi_q        <= '0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         cnt_q        <= cnt_d;
         j_q          <= j_d;
         emit_q       <= emit_d;
         best_valid_q <= best_valid_d;
         best_idx_q   <= best_idx_d;
         phi_q        <= phi_d;
      end
   end

   // The running minimum value is qualified by best_valid_q, so it needs no reset.
   always_ff @(posedge CLK) begin
      best_val_q <= best_val_d;
   end

   always_comb begin
      state_d      = state_q;
      n_d          = n_q;
      cnt_d        = cnt_q;
      j_d          = j_q;
      emit_d       = emit_q;
      best_valid_d = best_valid_q;
      best_idx_d   = best_idx_q;
      best_val_d   = best_val_q;
      phi_d        = phi_q;
      wr_en        = 1'b0;
      used_set     = 1'b0;
      used_clr     = 1'b0;

      n_start = (SIZE_N_IN >= DATA_SIZE'(DEPTH)) ? CW'(DEPTH) : CW'(SIZE_N_IN);
      // Unsigned compare orders non-negative IEEE-754 patterns correctly; strict < keeps ties stable.
      take = !used[j_q[AW-1:0]] && (!best_valid_q || (rd_data < best_val_q));

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               n_d      = n_start;
               cnt_d    = '0;
               emit_d   = '0;
               used_clr = 1'b1;
               state_d  = (n_start == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (U_IN_ENABLE) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + ONE_CW;
               if ((cnt_q + ONE_CW) == n_q) begin
                  j_d          = '0;
                  best_valid_d = 1'b0;
                  state_d      = ST_SCAN;
               end
            end
         end
         ST_SCAN: begin
            if (take) begin
               best_valid_d = 1'b1;
               best_idx_d   = j_q[AW-1:0];
               best_val_d   = rd_data;
            end
            j_d = j_q + ONE_CW;
            if (j_q == (n_q - ONE_CW)) begin
               phi_d   = take ? j_q[AW-1:0] : best_idx_q;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            used_set = 1'b1;
            emit_d   = emit_q + ONE_CW;
            if ((emit_q + ONE_CW) < n_q) begin
               j_d          = '0;
               best_valid_d = 1'b0;
               state_d      = ST_SCAN;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign U_OUT_ENABLE   = (state_q == ST_LOAD) && (cnt_q < n_q);
   assign PHI_OUT_ENABLE = (state_q == ST_EMIT);
   assign READY          = (state_q == ST_DONE);
   assign PHI_OUT        = DATA_SIZE'(phi_q);

endmodule

// File: tb/tb_accelerator_sort_controller.sv
// Directed bench for the usage-sort controller: table of sort jobs with
// hand-computed index orders and strobe cycles, plus a reset-abort sequence.
module tb_accelerator_sort_controller;

   localparam int DW    = 64;
   localparam int DEPTH = 8;

   localparam logic [DW-1:0] HALF    = 64'h3FE0_0000_0000_0000;
   localparam logic [DW-1:0] QUARTER = 64'h3FD0_0000_0000_0000;
   localparam logic [DW-1:0] ONE     = 64'h3FF0_0000_0000_0000;

   logic          CLK = 1'b0;
   logic          RST;
   logic          START;
   logic          READY;
   logic          U_IN_ENABLE;
   logic          U_OUT_ENABLE;
   logic          PHI_OUT_ENABLE;
   logic [DW-1:0] SIZE_N_IN;
   logic [DW-1:0] U_IN;
   logic [DW-1:0] PHI_OUT;

   accelerator_sort_controller #(
      .DATA_SIZE    (DW),
      .CONTROL_SIZE (64),
      .DEPTH        (DEPTH)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .START          (START),
      .READY          (READY),
      .U_IN_ENABLE    (U_IN_ENABLE),
      .U_OUT_ENABLE   (U_OUT_ENABLE),
      .PHI_OUT_ENABLE (PHI_OUT_ENABLE),
      .SIZE_N_IN      (SIZE_N_IN),
      .U_IN           (U_IN),
      .PHI_OUT        (PHI_OUT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            n_in;
      int            n_eff;
      int            n_pres;
      int            gap;
      logic [DW-1:0] u [10];
      int            phi [8];
      int            first_phi;
      int            ready_cyc;
      int            uoe_cycles;
      int            glitch_cyc;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int vi);
      vec_t v;
      int   phi_cnt;
      int   ready_cnt;
      int   ready_seen;
      int   uoe_cnt;
      int   slot;
      v          = vecs[vi];
      phi_cnt    = 0;
      ready_cnt  = 0;
      ready_seen = -1;
      uoe_cnt    = 0;
      for (int c = 0; c <= v.ready_cyc + 3; c++) begin
         @(negedge CLK);
         if (PHI_OUT_ENABLE) begin
            if (phi_cnt < v.n_eff) begin
               chk($sformatf("v%0d phi%0d index", vi, phi_cnt), PHI_OUT, DW'(v.phi[phi_cnt]));
               chk($sformatf("v%0d phi%0d cycle", vi, phi_cnt), DW'(c),
                   DW'(v.first_phi + phi_cnt * (v.n_eff + 1)));
            end
            phi_cnt++;
         end
         if (READY) begin
            if (ready_seen < 0) ready_seen = c;
            ready_cnt++;
         end
         if (U_OUT_ENABLE) uoe_cnt++;

         START       = (c == 0) || (v.glitch_cyc > 0 && c == v.glitch_cyc);
         SIZE_N_IN   = (c == 0) ? DW'(v.n_in) : DW'(7);
         U_IN_ENABLE = 1'b0;
         U_IN        = '0;
         if (c > 0 && (c % (v.gap + 1)) == 0) begin
            slot = c / (v.gap + 1);
            if (slot <= v.n_pres) begin
               U_IN_ENABLE = 1'b1;
               U_IN        = v.u[slot-1];
            end
         end
      end
      START       = 1'b0;
      U_IN_ENABLE = 1'b0;
      chk($sformatf("v%0d phi count", vi), DW'(phi_cnt), DW'(v.n_eff));
      chk($sformatf("v%0d ready cycle", vi), DW'(ready_seen), DW'(v.ready_cyc));
      chk($sformatf("v%0d ready pulses", vi), DW'(ready_cnt), DW'(1));
      chk($sformatf("v%0d u_out_enable cycles", vi), DW'(uoe_cnt), DW'(v.uoe_cycles));
      if (v.n_eff > 0) begin
         chk($sformatf("v%0d phi hold", vi), PHI_OUT, DW'(v.phi[v.n_eff-1]));
      end
   endtask

   task automatic chk_quiet(input string nm, input int ncyc);
      int noisy;
      noisy = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge CLK);
         if (READY || U_OUT_ENABLE || PHI_OUT_ENABLE || PHI_OUT != '0) noisy++;
      end
      chk(nm, DW'(noisy), DW'(0));
   endtask

   initial begin
      vecs[0].n_in = 4; vecs[0].n_eff = 4; vecs[0].n_pres = 4; vecs[0].gap = 0;
      vecs[0].u    = '{HALF, QUARTER, ONE, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
      vecs[0].phi  = '{3, 1, 0, 2, 0, 0, 0, 0};
      vecs[0].first_phi = 9; vecs[0].ready_cyc = 25; vecs[0].uoe_cycles = 4; vecs[0].glitch_cyc = 0;

      vecs[1].n_in = 3; vecs[1].n_eff = 3; vecs[1].n_pres = 3; vecs[1].gap = 0;
      vecs[1].u    = '{HALF, HALF, HALF, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
      vecs[1].phi  = '{0, 1, 2, 0, 0, 0, 0, 0};
      vecs[1].first_phi = 7; vecs[1].ready_cyc = 16; vecs[1].uoe_cycles = 3; vecs[1].glitch_cyc = 0;

      vecs[2].n_in = 0; vecs[2].n_eff = 0; vecs[2].n_pres = 0; vecs[2].gap = 0;
      vecs[2].u    = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
      vecs[2].phi  = '{0, 0, 0, 0, 0, 0, 0, 0};
      vecs[2].first_phi = 0; vecs[2].ready_cyc = 1; vecs[2].uoe_cycles = 0; vecs[2].glitch_cyc = 0;

      // Elements 9 and 10 carry the smallest value; they must never reach the buffer.
      vecs[3].n_in = 10; vecs[3].n_eff = 8; vecs[3].n_pres = 10; vecs[3].gap = 0;
      vecs[3].u    = '{64'd7, 64'd3, 64'd5, 64'd0, 64'd6, 64'd1, 64'd4, 64'd2, 64'd0, 64'd0};
      vecs[3].phi  = '{3, 5, 7, 1, 6, 2, 4, 0};
      vecs[3].first_phi = 17; vecs[3].ready_cyc = 81; vecs[3].uoe_cycles = 8; vecs[3].glitch_cyc = 0;

      vecs[4].n_in = 4; vecs[4].n_eff = 4; vecs[4].n_pres = 4; vecs[4].gap = 2;
      vecs[4].u    = '{HALF, QUARTER, ONE, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
      vecs[4].phi  = '{3, 1, 0, 2, 0, 0, 0, 0};
      vecs[4].first_phi = 17; vecs[4].ready_cyc = 33; vecs[4].uoe_cycles = 12; vecs[4].glitch_cyc = 0;

      vecs[5].n_in = 2; vecs[5].n_eff = 2; vecs[5].n_pres = 2; vecs[5].gap = 0;
      vecs[5].u    = '{ONE, QUARTER, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
      vecs[5].phi  = '{1, 0, 0, 0, 0, 0, 0, 0};
      vecs[5].first_phi = 5; vecs[5].ready_cyc = 9; vecs[5].uoe_cycles = 2; vecs[5].glitch_cyc = 3;

      RST         = 1'b0;
      START       = 1'b0;
      U_IN_ENABLE = 1'b0;
      SIZE_N_IN   = '0;
      U_IN        = '0;
      repeat (2) @(negedge CLK);
      chk("reset READY", DW'(READY), DW'(0));
      chk("reset U_OUT_ENABLE", DW'(U_OUT_ENABLE), DW'(0));
      chk("reset PHI_OUT_ENABLE", DW'(PHI_OUT_ENABLE), DW'(0));
      chk("reset PHI_OUT", PHI_OUT, DW'(0));
      RST = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 5; i++) begin
         run_vec(i);
      end

      // Abort a sort during its second scan, then run a fresh job with a stray START.
      @(negedge CLK);
      START     = 1'b1;
      SIZE_N_IN = DW'(4);
      for (int c = 1; c <= 10; c++) begin
         @(negedge CLK);
         START       = 1'b0;
         U_IN_ENABLE = (c <= 4);
         U_IN        = (c <= 4) ? vecs[0].u[c-1] : '0;
      end
      @(negedge CLK);
      U_IN_ENABLE = 1'b0;
      RST         = 1'b0;
      #1;
      chk("abort READY", DW'(READY), DW'(0));
      chk("abort U_OUT_ENABLE", DW'(U_OUT_ENABLE), DW'(0));
      chk("abort PHI_OUT_ENABLE", DW'(PHI_OUT_ENABLE), DW'(0));
      chk("abort PHI_OUT", PHI_OUT, DW'(0));
      chk_quiet("outputs during reset", 3);
      RST = 1'b1;
      chk_quiet("outputs after abort", 4);
      run_vec(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
